// File: rtl/apb4_i2c_regbank_if.sv
// ---------------------------------------------------------------------------
// apb4_i2c_regbank_if
//
// APB4 bus bundle between the system APB master and the I2C register bank.
//
// Parameters:
//   DATA_WIDTH  APB data width (8, 16 or 32)
//   ADDR_WIDTH  APB byte-address width
//
// Signals:
//   paddr    byte address                (master -> slave)
//   psel     slave select                (master -> slave)
//   penable  access phase                (master -> slave)
//   pwrite   1 = write, 0 = read         (master -> slave)
//   pwdata   write data                  (master -> slave)
//   pstrb    byte write strobes          (master -> slave)
//   prdata   read data                   (slave -> master)
//   pready   transfer complete           (slave -> master)
//   pslverr  transfer error              (slave -> master)
// ---------------------------------------------------------------------------
interface apb4_i2c_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb4_i2c_regbank.sv
// ---------------------------------------------------------------------------
// apb4_i2c_regbank
//
// APB4 register bank in front of the I2C core. Decodes the register map,
// inserts programmable wait states, applies byte strobes, reports transfer
// errors, generates single-cycle TX-push / RX-pop strobes toward the FIFOs
// and owns the self-clearing START / SRST command bits.
//
// Register map (byte offsets):
//   0x00 TXDATA   WO [7:0]   write pushes a byte into the TX FIFO
//   0x04 RXDATA   RO [7:0]   read returns the RX FIFO head and pops it
//   0x08 STATUS   RO [7:0]   status_i pass-through
//   0x0C SADDR    RW [6:0]   target address
//   0x10 CMD      RW [7:0]   bit0 START, bit1 SRST self-clear on core ack
//   0x14 PRESCALE RW [15:0]  SCL prescaler, resets to 16'h00C8
//
// Optional feature macro:
//   APB_SLVERR_EN  when defined pslverr flags error transfers; otherwise
//                  pslverr is tied low (error cases are still suppressed).
//
// Parameters:
//   DATA_WIDTH   APB data width (8, 16, 32)
//   ADDR_WIDTH   APB address width, word index is paddr[ADDR_WIDTH-1:2]
//   WAIT_STATES  access cycles with pready low before completion (0..15)
//
// Ports:
//   pclk_i        clock
//   preset_ni     asynchronous active-low reset
//   apb           APB4 slave bus (apb4_i2c_regbank_if.slave)
//   status_i      I2C/FIFO status
//   tx_full_i     TX FIFO full
//   rx_empty_i    RX FIFO empty
//   rx_data_i     RX FIFO head byte
//   start_done_i  core accepted START
//   reset_done_i  core soft reset complete
//   tx_data_o     byte to push, valid with tx_push_o
//   tx_push_o     one-cycle TX push strobe
//   rx_pop_o      one-cycle RX pop strobe
//   slave_addr_o  SADDR register
//   command_o     CMD register
//   prescale_o    PRESCALE register
// ---------------------------------------------------------------------------
module apb4_i2c_regbank #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk_i,
  input  logic              preset_ni,
  apb4_i2c_regbank_if.slave apb,
  input  logic [7:0]        status_i,
  input  logic              tx_full_i,
  input  logic              rx_empty_i,
  input  logic [7:0]        rx_data_i,
  input  logic              start_done_i,
  input  logic              reset_done_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_push_o,
  output logic              rx_pop_o,
  output logic [6:0]        slave_addr_o,
  output logic [7:0]        command_o,
  output logic [15:0]       prescale_o
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

  localparam logic [IDX_WIDTH-1:0] IDX_TXDATA   = IDX_WIDTH'(0);
  localparam logic [IDX_WIDTH-1:0] IDX_RXDATA   = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_STATUS   = IDX_WIDTH'(2);
  localparam logic [IDX_WIDTH-1:0] IDX_SADDR    = IDX_WIDTH'(3);
  localparam logic [IDX_WIDTH-1:0] IDX_CMD      = IDX_WIDTH'(4);
  localparam logic [IDX_WIDTH-1:0] IDX_PRESCALE = IDX_WIDTH'(5);

  localparam logic [15:0] PRESCALE_RESET = 16'h00C8;
  localparam logic [3:0]  WAIT_LOAD      = 4'(WAIT_STATES);

  logic [3:0]           wait_cnt;
  logic                 setup_phase;
  logic                 access_phase;
  logic                 xfer_done;

  logic [IDX_WIDTH-1:0] word_idx;
  logic                 aligned;
  logic                 mapped;
  logic [31:0]          wdata_ext;
  logic [3:0]           strb_ext;

  logic [31:0]          rd_value;
  logic                 access_err;
  logic                 hit_tx;
  logic                 hit_rx;
  logic                 hit_saddr;
  logic                 hit_cmd;
  logic                 hit_prescale;

  logic                 wr_ok;
  logic                 do_push;
  logic                 do_pop;
  logic                 wr_saddr;
  logic                 wr_cmd;
  logic                 wr_prescale;

  logic [7:0]           command_next;
  logic [15:0]          prescale_next;
  logic                 unused_bits;

  // ---------------------------------------------------------------------
  // Handshake phases. pready is purely combinational so that the zero
  // wait-state case completes in the classic two-cycle APB transfer.
  // ---------------------------------------------------------------------
  assign setup_phase  = apb.psel & ~apb.penable;
  assign access_phase = apb.psel &  apb.penable;
  assign xfer_done    = access_phase & (wait_cnt == 4'd0);
  assign apb.pready   = xfer_done;

  // The counter is reloaded in every setup phase, which is what makes
  // back-to-back transfers work without an idle cycle in between.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      wait_cnt <= 4'd0;
    end else if (setup_phase) begin
      wait_cnt <= WAIT_LOAD;
    end else if (access_phase && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Address decode. Data and strobes are normalised to 32/4 bits so the
  // register logic is independent of DATA_WIDTH; missing upper lanes read
  // as zero and can never be strobed.
  // ---------------------------------------------------------------------
  assign word_idx  = apb.paddr[ADDR_WIDTH-1:2];
  assign aligned   = (apb.paddr[1:0] == 2'b00);
  assign mapped    = (word_idx <= IDX_PRESCALE);
  assign wdata_ext = 32'(apb.pwdata);
  assign strb_ext  = 4'(apb.pstrb);

  always_comb begin
    rd_value     = 32'd0;
    access_err   = 1'b0;
    hit_tx       = 1'b0;
    hit_rx       = 1'b0;
    hit_saddr    = 1'b0;
    hit_cmd      = 1'b0;
    hit_prescale = 1'b0;

    if (!aligned || !mapped) begin
      access_err = 1'b1;
    end else begin
      case (word_idx)
        IDX_TXDATA: begin
          // Write-only: reading it is an error; writing into a full FIFO
          // drops the byte and flags an error.
          hit_tx     = 1'b1;
          access_err = apb.pwrite ? tx_full_i : 1'b1;
        end
        IDX_RXDATA: begin
          if (apb.pwrite || rx_empty_i) begin
            access_err = 1'b1;
          end else begin
            hit_rx   = 1'b1;
            rd_value = {24'd0, rx_data_i};
          end
        end
        IDX_STATUS: begin
          if (apb.pwrite) begin
            access_err = 1'b1;
          end else begin
            rd_value = {24'd0, status_i};
          end
        end
        IDX_SADDR: begin
          hit_saddr = 1'b1;
          rd_value  = {25'd0, slave_addr_o};
        end
        IDX_CMD: begin
          hit_cmd  = 1'b1;
          rd_value = {24'd0, command_o};
        end
        IDX_PRESCALE: begin
          hit_prescale = 1'b1;
          rd_value     = {16'd0, prescale_o};
        end
        default: begin
          access_err = 1'b1;
        end
      endcase
    end
  end

  // Every side effect is qualified by the completion cycle and by the
  // absence of an error, so error transfers never disturb state.
  assign wr_ok       = xfer_done & apb.pwrite & ~access_err;
  assign do_push     = wr_ok & hit_tx & strb_ext[0];
  assign do_pop      = xfer_done & ~apb.pwrite & hit_rx & ~access_err;
  assign wr_saddr    = wr_ok & hit_saddr & strb_ext[0];
  assign wr_cmd      = wr_ok & hit_cmd & strb_ext[0];
  assign wr_prescale = wr_ok & hit_prescale;

  assign apb.prdata = (xfer_done & ~apb.pwrite) ? rd_value[DATA_WIDTH-1:0]
                                                : '0;

`ifdef APB_SLVERR_EN
  assign apb.pslverr = xfer_done & access_err;
`else
  assign apb.pslverr = 1'b0;
`endif

  // Only byte lanes 0 and 1 carry register content.
  assign unused_bits = ^{wdata_ext[31:16], strb_ext[3:2]};

  // ---------------------------------------------------------------------
  // Next-state for CMD and PRESCALE. The core acknowledges are applied
  // first so that a strobed APB write in the same cycle overrides them.
  // ---------------------------------------------------------------------
  always_comb begin
    command_next = command_o;
    if (start_done_i) begin
      command_next[0] = 1'b0;
    end
    if (reset_done_i) begin
      command_next[1] = 1'b0;
    end
    if (wr_cmd) begin
      command_next = wdata_ext[7:0];
    end
  end

  always_comb begin
    prescale_next = prescale_o;
    if (wr_prescale && strb_ext[0]) begin
      prescale_next[7:0] = wdata_ext[7:0];
    end
    if (wr_prescale && strb_ext[1]) begin
      prescale_next[15:8] = wdata_ext[15:8];
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      slave_addr_o <= 7'd0;
      command_o    <= 8'd0;
      prescale_o   <= PRESCALE_RESET;
    end else begin
      if (wr_saddr) begin
        slave_addr_o <= wdata_ext[6:0];
      end
      command_o  <= command_next;
      prescale_o <= prescale_next;
    end
  end

  // FIFO strobes are registered: they fire in the cycle after the
  // completion edge, with tx_data_o holding the pushed byte in that cycle.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      tx_push_o <= 1'b0;
      rx_pop_o  <= 1'b0;
      tx_data_o <= 8'd0;
    end else begin
      tx_push_o <= do_push;
      rx_pop_o  <= do_pop;
      if (do_push) begin
        tx_data_o <= wdata_ext[7:0];
      end
    end
  end

endmodule
